// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared encodings and state type for the writeback stage
package wb_pkg;

    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MEM = 2'b01;
    localparam logic [1:0] MTR_PC4 = 2'b10;
    localparam logic [1:0] MTR_AUX = 2'b11;

    localparam logic [1:0] LS_WORD = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_BYTE = 2'b10;

    typedef enum logic {
        WB_IDLE,
        WB_WAIT_LOAD
    } wb_state_t;

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - little-endian byte/halfword lane select with sign or zero extension
module load_extend
    import wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]             data,
    input  logic [1:0]                    load_size,
    input  logic                          load_unsigned,
    input  logic [$clog2(DATA_W/8)-1:0]   byte_offset,
    output logic [DATA_W-1:0]             result
);

    localparam int OFF_W = $clog2(DATA_W/8);

    logic [OFF_W-1:0] half_offset;
    logic [7:0]       lane_b;
    logic [15:0]      lane_h;

    // Halfword lanes are aligned: the low offset bit is ignored.
    assign half_offset = byte_offset & ~OFF_W'(1);
    assign lane_b      = data[{byte_offset, 3'b000} +: 8];
    assign lane_h      = data[{half_offset, 3'b000} +: 16];

    always_comb begin
        result = data;
        case (load_size)
            LS_BYTE: result = {{(DATA_W-8){~load_unsigned & lane_b[7]}}, lane_b};
            LS_HALF: result = {{(DATA_W-16){~load_unsigned & lane_h[15]}}, lane_h};
            default: result = data;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - registered handshaked writeback select; WB_LOAD_EXT_EN enables load extraction
module writeback_stage
    import wb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          flush,
    input  logic [1:0]                    memtoreg,
    input  logic                          reg_write,
    input  logic [REG_ADDR_W-1:0]         write_reg,
    input  logic [DATA_W-1:0]             alu_result,
    input  logic [DATA_W-1:0]             pc_plus_four,
    input  logic [DATA_W-1:0]             aux_in,
    input  logic [1:0]                    load_size,
    input  logic                          load_unsigned,
    input  logic [$clog2(DATA_W/8)-1:0]   byte_offset,
    input  logic                          mem_rvalid,
    input  logic [DATA_W-1:0]             memory_out,
    output logic                          rf_we,
    output logic [REG_ADDR_W-1:0]         rf_waddr,
    output logic [DATA_W-1:0]             rf_wdata,
    output logic                          busy
);

    localparam int OFF_W = $clog2(DATA_W/8);

    wb_state_t state, state_nxt;

    logic [1:0]            h_memtoreg;
    logic                  h_reg_write;
    logic [REG_ADDR_W-1:0] h_write_reg;
    logic [1:0]            h_load_size;
    logic                  h_load_unsigned;
    logic [OFF_W-1:0]      h_byte_offset;
    logic [DATA_W-1:0]     h_data;

    logic                  accept;
    logic [DATA_W-1:0]     sel_data;
    logic [DATA_W-1:0]     load_data;
    logic [1:0]            ext_size;
    logic                  ext_unsigned;
    logic [OFF_W-1:0]      ext_offset;

    logic                  commit_we;
    logic [REG_ADDR_W-1:0] commit_addr;
    logic [DATA_W-1:0]     commit_data;

    assign in_ready = (state == WB_IDLE);
    assign busy     = (state == WB_WAIT_LOAD);
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        sel_data = alu_result;
        case (memtoreg)
            MTR_PC4: sel_data = pc_plus_four;
            MTR_AUX: sel_data = aux_in;
            default: sel_data = alu_result;
        endcase
    end

    // A waiting load formats with the fields captured at accept, not the live inputs.
    assign ext_size     = busy ? h_load_size     : load_size;
    assign ext_unsigned = busy ? h_load_unsigned : load_unsigned;
    assign ext_offset   = busy ? h_byte_offset   : byte_offset;

`ifdef WB_LOAD_EXT_EN
    load_extend #(
        .DATA_W (DATA_W)
    ) u_load_extend (
        .data          (memory_out),
        .load_size     (ext_size),
        .load_unsigned (ext_unsigned),
        .byte_offset   (ext_offset),
        .result        (load_data)
    );
`else
    logic unused_ext;
    assign unused_ext = ^{ext_size, ext_unsigned, ext_offset};
    assign load_data  = memory_out;
`endif

    always_comb begin
        state_nxt   = state;
        commit_we   = 1'b0;
        commit_addr = write_reg;
        commit_data = sel_data;
        case (state)
            WB_IDLE: begin
                if (accept) begin
                    if (memtoreg != MTR_MEM || mem_rvalid) begin
                        commit_we   = reg_write && (write_reg != '0);
                        commit_data = (memtoreg == MTR_MEM) ? load_data : sel_data;
                    end else begin
                        state_nxt = WB_WAIT_LOAD;
                    end
                end
            end
            WB_WAIT_LOAD: begin
                // flush beats a same-cycle memory response
                if (flush) begin
                    state_nxt = WB_IDLE;
                end else if (mem_rvalid) begin
                    state_nxt   = WB_IDLE;
                    commit_we   = h_reg_write && (h_write_reg != '0);
                    commit_addr = h_write_reg;
                    commit_data = (h_memtoreg == MTR_MEM) ? load_data : h_data;
                end
            end
            default: state_nxt = WB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= WB_IDLE;
            rf_we           <= 1'b0;
            rf_waddr        <= '0;
            rf_wdata        <= '0;
            h_memtoreg      <= '0;
            h_reg_write     <= 1'b0;
            h_write_reg     <= '0;
            h_load_size     <= '0;
            h_load_unsigned <= 1'b0;
            h_byte_offset   <= '0;
            h_data          <= '0;
        end else begin
            state <= state_nxt;
            rf_we <= commit_we;
            if (commit_we) begin
                rf_waddr <= commit_addr;
                rf_wdata <= commit_data;
            end
            if (accept) begin
                h_memtoreg      <= memtoreg;
                h_reg_write     <= reg_write;
                h_write_reg     <= write_reg;
                h_load_size     <= load_size;
                h_load_unsigned <= load_unsigned;
                h_byte_offset   <= byte_offset;
                h_data          <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - vector table plus scoreboard bench for writeback_stage
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, flush;
    logic [1:0]  memtoreg;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] alu_result, pc_plus_four, aux_in;
    logic [1:0]  load_size;
    logic        load_unsigned;
    logic [1:0]  byte_offset;
    logic        mem_rvalid;
    logic [31:0] memory_out;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        busy;

    always #5 clk = ~clk;

    writeback_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .flush         (flush),
        .memtoreg      (memtoreg),
        .reg_write     (reg_write),
        .write_reg     (write_reg),
        .alu_result    (alu_result),
        .pc_plus_four  (pc_plus_four),
        .aux_in        (aux_in),
        .load_size     (load_size),
        .load_unsigned (load_unsigned),
        .byte_offset   (byte_offset),
        .mem_rvalid    (mem_rvalid),
        .memory_out    (memory_out),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .busy          (busy)
    );

`ifdef WB_LOAD_EXT_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [1:0]  mtr;
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] aux;
        logic [31:0] mem;
        logic [1:0]  ls;
        logic        uns;
        logic [1:0]  off;
        logic        exp_we;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        string       name;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    localparam int NV = 14;
    localparam logic [31:0] MW = 32'h80FF7F01;

    vec_t vecs[NV];
    exp_t sb[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(string name, logic [1:0] mtr, logic rw, logic [4:0] wr,
                                logic [31:0] alu, logic [31:0] pc4, logic [31:0] aux,
                                logic [1:0] ls, logic uns, logic [1:0] off,
                                logic exp_we, logic [31:0] exp_data);
        vec_t v;
        v.name = name; v.mtr = mtr; v.rw = rw; v.wr = wr;
        v.alu = alu; v.pc4 = pc4; v.aux = aux; v.mem = MW;
        v.ls = ls; v.uns = uns; v.off = off;
        v.exp_we = exp_we; v.exp_data = exp_data;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Advance one cycle and compare any write pulse against the scoreboard.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (!rst && rf_we) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write got=(%0d,%h) expected=none", rf_waddr, rf_wdata);
            end else begin
                e = sb.pop_front();
                if (rf_waddr !== e.addr || rf_wdata !== e.data) begin
                    failures++;
                    $display("FAIL %s got=(%0d,%h) expected=(%0d,%h)",
                             e.name, rf_waddr, rf_wdata, e.addr, e.data);
                end
            end
        end
    endtask

    task automatic quiet();
        in_valid = 1'b0; flush = 1'b0; mem_rvalid = 1'b0;
    endtask

    task automatic present(logic [1:0] mtr, logic [4:0] wr, logic [31:0] d);
        in_valid = 1'b1; memtoreg = mtr; reg_write = 1'b1; write_reg = wr;
        alu_result = d; pc_plus_four = d; aux_in = d;
        load_size = 2'b00; load_unsigned = 1'b0; byte_offset = 2'b00;
    endtask

    initial begin
        rst = 1'b1;
        quiet();
        memtoreg = '0; reg_write = 1'b0; write_reg = '0;
        alu_result = '0; pc_plus_four = '0; aux_in = '0;
        load_size = '0; load_unsigned = 1'b0; byte_offset = '0; memory_out = '0;

        vecs[0]  = mk("alu_r8",     2'b00, 1, 5'd8,  32'h11, 32'h0, 32'h0, 2'b00, 0, 2'd0, 1, 32'h11);
        vecs[1]  = mk("alu_r9",     2'b00, 1, 5'd9,  32'h22, 32'h0, 32'h0, 2'b00, 0, 2'd0, 1, 32'h22);
        vecs[2]  = mk("link_r31",   2'b10, 1, 5'd31, 32'h5,  32'h00400008, 32'h0, 2'b00, 0, 2'd0, 1, 32'h00400008);
        vecs[3]  = mk("reg0",       2'b00, 1, 5'd0,  32'h77, 32'h0, 32'h0, 2'b00, 0, 2'd0, 0, 32'h0);
        vecs[4]  = mk("aux_r5",     2'b11, 1, 5'd5,  32'h1,  32'h2, 32'hA5A50001, 2'b00, 0, 2'd0, 1, 32'hA5A50001);
        vecs[5]  = mk("no_rw",      2'b00, 0, 5'd6,  32'h66, 32'h0, 32'h0, 2'b00, 0, 2'd0, 0, 32'h0);
        vecs[6]  = mk("ld_word",    2'b01, 1, 5'd7,  32'h0,  32'h0, 32'h0, 2'b00, 0, 2'd1, 1, MW);
        vecs[7]  = mk("ld_b2_s",    2'b01, 1, 5'd10, 32'h0,  32'h0, 32'h0, 2'b10, 0, 2'd2, 1, EXT ? 32'hFFFFFFFF : MW);
        vecs[8]  = mk("ld_b3_u",    2'b01, 1, 5'd11, 32'h0,  32'h0, 32'h0, 2'b10, 1, 2'd3, 1, EXT ? 32'h00000080 : MW);
        vecs[9]  = mk("ld_h2_s",    2'b01, 1, 5'd12, 32'h0,  32'h0, 32'h0, 2'b01, 0, 2'd2, 1, EXT ? 32'hFFFF80FF : MW);
        vecs[10] = mk("ld_b0_s",    2'b01, 1, 5'd13, 32'h0,  32'h0, 32'h0, 2'b10, 0, 2'd0, 1, EXT ? 32'h00000001 : MW);
        vecs[11] = mk("ld_h0_u",    2'b01, 1, 5'd14, 32'h0,  32'h0, 32'h0, 2'b01, 1, 2'd0, 1, EXT ? 32'h00007F01 : MW);
        vecs[12] = mk("ld_h3_u",    2'b01, 1, 5'd15, 32'h0,  32'h0, 32'h0, 2'b01, 1, 2'd3, 1, EXT ? 32'h000080FF : MW);
        vecs[13] = mk("ld_ls3",     2'b01, 1, 5'd16, 32'h0,  32'h0, 32'h0, 2'b11, 0, 2'd3, 1, MW);

        tick();
        tick();
        rst = 1'b0;
        chk("reset_rf_we",    32'(rf_we), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_busy",     32'(busy), 32'd0);
        chk("reset_rf_waddr", 32'(rf_waddr), 32'd0);
        chk("reset_rf_wdata", rf_wdata, 32'd0);

        // Back-to-back retirements; loads see their response in the accept cycle.
        for (int i = 0; i < NV; i++) begin
            in_valid = 1'b1; flush = 1'b0; mem_rvalid = 1'b1;
            memtoreg = vecs[i].mtr; reg_write = vecs[i].rw; write_reg = vecs[i].wr;
            alu_result = vecs[i].alu; pc_plus_four = vecs[i].pc4; aux_in = vecs[i].aux;
            memory_out = vecs[i].mem; load_size = vecs[i].ls;
            load_unsigned = vecs[i].uns; byte_offset = vecs[i].off;
            if (vecs[i].exp_we) sb.push_back('{vecs[i].name, vecs[i].wr, vecs[i].exp_data});
            tick();
            chk("table_in_ready", 32'(in_ready), 32'd1);
        end
        quiet();
        tick();
        chk("hold_rf_waddr", 32'(rf_waddr), 32'(vecs[NV-1].wr));
        chk("hold_rf_wdata", rf_wdata, vecs[NV-1].exp_data);

        // Delayed load; a competing instruction is offered while the stage is stalled.
        present(2'b01, 5'd4, 32'h0);
        tick();
        present(2'b00, 5'd20, 32'hBAD0BAD0);
        for (int c = 0; c < 3; c++) begin
            chk("wait_in_ready", 32'(in_ready), 32'd0);
            chk("wait_busy", 32'(busy), 32'd1);
            if (c < 2) tick();
        end
        mem_rvalid = 1'b1; memory_out = 32'hDEADBEEF;
        sb.push_back('{"delayed_load", 5'd4, 32'hDEADBEEF});
        tick();
        quiet();
        chk("after_load_in_ready", 32'(in_ready), 32'd1);
        chk("after_load_busy", 32'(busy), 32'd0);
        tick();

        // Flush colliding with the memory response, then a normal write.
        present(2'b01, 5'd21, 32'h0);
        tick();
        in_valid = 1'b0; flush = 1'b1; mem_rvalid = 1'b1; memory_out = 32'h12345678;
        tick();
        quiet();
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_busy", 32'(busy), 32'd0);
        present(2'b00, 5'd22, 32'h00001313);
        sb.push_back('{"post_flush_write", 5'd22, 32'h00001313});
        tick();
        quiet();

        // Flush in IDLE blocks acceptance; a stray response in IDLE is ignored.
        present(2'b00, 5'd23, 32'hFEEDFACE);
        flush = 1'b1;
        tick();
        quiet();
        mem_rvalid = 1'b1; memory_out = 32'h0BADF00D;
        tick();
        quiet();
        tick();

        // Reset during a pending load abandons it.
        present(2'b01, 5'd24, 32'h0);
        tick();
        quiet();
        chk("preload_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_rf_we", 32'(rf_we), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rf_wdata", rf_wdata, 32'd0);
        mem_rvalid = 1'b1; memory_out = 32'hCAFEF00D;
        tick();
        quiet();
        tick();

        chk("pending_writes", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Parametrised MIPS writeback stage that replaces the combinational write-data select with a registered, handshaked unit. It accepts one retiring instruction per cycle from the memory stage and selects the register-file write data from ALU result, load data, PC+4 or an auxiliary source. Load results that return late are held until the memory response arrives. It drives the register-file write port and the forwarding path, with optional byte/halfword load extraction.

## Interface
- DATA_W, 32: datapath width; multiple of 8, at least 16.
- REG_ADDR_W, 5: register-file address width.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  memory stage presents an instruction.
- in_ready  out  1  stage can accept; 1 in IDLE, 0 in WAIT_LOAD.
- flush  in  1  drop the pending instruction; no write.
- memtoreg  in  2  source: 00 alu_result, 01 memory_out, 10 pc_plus_four, 11 aux_in.
- reg_write  in  1  instruction writes the register file.
- write_reg  in  REG_ADDR_W  destination register.
- alu_result, pc_plus_four, aux_in  in  DATA_W  candidate write data.
- load_size  in  2  00 word, 01 half, 10 byte, 11 treated as word.
- load_unsigned  in  1  zero-extend (1) or sign-extend (0).
- byte_offset  in  $clog2(DATA_W/8)  low address bits of the load.
- mem_rvalid  in  1  memory_out valid this cycle.
- memory_out  in  DATA_W  raw load data word.
- rf_we  out  1  register-file write enable, one-cycle pulse.
- rf_waddr  out  REG_ADDR_W  register-file write address.
- rf_wdata  out  DATA_W  register-file write data.
- busy  out  1  a load is pending in WAIT_LOAD.

## Operation
- Acceptance: a transfer occurs when in_valid && in_ready && !flush. The stage latches memtoreg, write_reg, reg_write, the load-format fields and the non-load data into a holding register.
- States:
  - IDLE: accept. If memtoreg != 01, or memtoreg == 01 with mem_rvalid in the same cycle, commit, stay IDLE. If memtoreg == 01 without mem_rvalid, go to WAIT_LOAD.
  - WAIT_LOAD: in_ready = 0. When mem_rvalid is seen, capture memory_out, commit and return to IDLE.
- Commit: on the next edge, rf_we = latched reg_write && (write_reg != 0), with rf_waddr and rf_wdata registered. A write to register 0 never pulses rf_we.
- Data selection:
  - 00 alu_result; 01 extracted load data; 10 pc_plus_four; 11 aux_in.
  - Widths are all DATA_W; there is no arithmetic.
- flush:
  - In WAIT_LOAD, discards the pending load and returns to IDLE; no write.
  - In IDLE, blocks acceptance that cycle.
  - A flush in the same cycle as mem_rvalid in WAIT_LOAD wins: no write.
- mem_rvalid in IDLE with no load being accepted is ignored.
- rf_waddr and rf_wdata hold their last values when rf_we = 0.

## Timing
- Reset values: state IDLE, in_ready 1, busy 0, rf_we 0, rf_waddr 0, rf_wdata 0, holding register 0.
- Reset asserted mid-load abandons the load; no write after release.
- Non-load latency: 1 cycle from accept edge to rf_we.
- Load latency: 1 cycle after the edge at which mem_rvalid is sampled.
- Throughput: one instruction per cycle when no load is waiting.
- in_ready and busy are registered state decodes with no combinational path from inputs.

## Configuration
- WB_LOAD_EXT_EN defined:
  - Byte loads: select lane byte_offset, little-endian, then extend to DATA_W.
  - Half loads: select lane byte_offset[MSB:1], then extend.
  - Extension is sign or zero per load_unsigned.
- WB_LOAD_EXT_EN undefined: memory_out passes unmodified. load_size, load_unsigned and byte_offset are ignored.

## Structure
- Package wb_pkg holds:
  - memtoreg encodings (MTR_ALU, MTR_MEM, MTR_PC4, MTR_AUX);
  - load_size encodings (LS_WORD, LS_HALF, LS_BYTE);
  - the state enum (WB_IDLE, WB_WAIT_LOAD).
- Sub-module load_extend: purely combinational lane select and extension, instantiated only under WB_LOAD_EXT_EN.

## Test plan
- Reset:
  - Assert rst mid-WAIT_LOAD, then release -> rf_we 0, in_ready 1, busy 0, rf_wdata 0.
- Back-to-back ALU writes:
  - Stimulus: memtoreg 00, write_reg 8, alu_result 0x00000011 then write_reg 9, alu_result 0x00000022.
  - Response: rf_we pulses on consecutive cycles with (8, 0x11) then (9, 0x22).
- Delayed load:
  - Stimulus: memtoreg 01, write_reg 4, mem_rvalid 3 cycles later with memory_out 0xDEADBEEF.
  - Response: in_ready 0 for 3 cycles; rf_we one cycle after mem_rvalid with (4, 0xDEADBEEF).
- Byte extraction (WB_LOAD_EXT_EN), memory_out 0x80FF7F01:
  - byte_offset 2, signed -> 0xFFFFFFFF;
  - byte_offset 3, unsigned -> 0x00000080;
  - half, byte_offset 2, signed -> 0xFFFF80FF.
- Register 0 and link:
  - write_reg 0, reg_write 1 -> no rf_we.
  - memtoreg 10, write_reg 31, pc_plus_four 0x00400008 -> (31, 0x00400008).
- Flush:
  - flush with mem_rvalid in the same WAIT_LOAD cycle -> no rf_we, back to IDLE.
  - The next accepted instruction writes normally.
